ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter A, default 10, address width of the shared RAM.
REQ-002 Parameter D, default 8, data width of the shared RAM.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 pN_req  input  1  (N=0,1) requester N access request; held stable with its qualifiers until granted.
REQ-006 pN_we  input  1  (N=0,1) 1=write, 0=read.
REQ-007 pN_addr  input  A  (N=0,1) access address.
REQ-008 pN_wdata  input  D  (N=0,1) write data.
REQ-009 pN_gnt  output  1  (N=0,1) access accepted this cycle.
REQ-010 pN_rvalid  output  1  (N=0,1) one-cycle pulse: pN_rdata carries read data.
REQ-011 pN_rdata  output  D  (N=0,1) read data, held until the next read return to port N.
REQ-012 ram_cs  output  1  RAM chip select.
REQ-013 ram_rw  output  1  RAM direction, 1=write, 0=read.
REQ-014 ram_addr  output  A  RAM address.
REQ-015 ram_di  output  D  RAM write data.
REQ-016 ram_dout  input  D  RAM read data, valid one clock after a read-issue cycle.

Function
REQ-017 The RAM is synchronous: it samples cs/rw/addr/di at posedge clk; read data appears on ram_dout after that edge.
REQ-018 At most one pN_gnt is high in any cycle; grants are combinational from pN_req and the registered priority pointer prio.
REQ-019 Only one port requesting -> that port is granted in the same cycle, regardless of prio.
REQ-020 Both ports requesting -> the port equal to prio is granted.
REQ-021 After any grant to port k, prio becomes 1-k at the next edge; with no grant, prio holds.
REQ-022 Grant cycle: ram_cs=1, ram_rw=pk_we, ram_addr=pk_addr, ram_di=pk_wdata of the granted port k.
REQ-023 No grant: ram_cs=0, ram_rw=0, ram_addr=0, ram_di=0.
REQ-024 A granted read sets a pending-read register (valid, port tag k); a granted write or no grant clears it.
REQ-025 A pending read with tag k produces pk_rvalid=1 for exactly one cycle, the cycle after the grant; pk_rdata is registered from ram_dout on that cycle's closing edge and is also driven combinationally from ram_dout while pk_rvalid=1.
REQ-026 Read latency: grant on cycle T -> pk_rvalid and correct data on cycle T+1.
REQ-027 Throughput: one access per cycle; a read return on T+1 and a new grant on T+1 occur together without stall.
REQ-028 Back-to-back reads alternate between ports when both request continuously; neither port waits more than one cycle.
REQ-029 A write followed by a read of the same address on the next cycle returns the written data.
REQ-030 pN_rvalid is never asserted for a write or for a port without a pending read.

Reset
REQ-031 While rst_n=0: prio=0, pending-read valid=0, pN_rdata=0, pN_rvalid=0.
REQ-032 While rst_n=0: pN_gnt=0 and ram_cs=0 irrespective of requests.
REQ-033 rst_n asserted mid-operation: any in-flight read return is discarded; no rvalid pulse follows reset release.
REQ-034 First cycle after rst_n release: arbitration resumes with prio=0.

Verification
REQ-035 Reset release, p0 read addr 0x010 (RAM holds 0xA5) -> p0_gnt on T, p0_rvalid on T+1 with p0_rdata=0xA5, p1 outputs idle.
REQ-036 Both ports request reads continuously from reset -> grants p0,p1,p0,p1 on consecutive cycles; each rvalid one cycle after its grant on the matching port.
REQ-037 p1 writes 0x3C to 0x3FF on T, p0 reads 0x3FF on T+1 -> p0_rdata=0x3C on T+2, ram_rw=1 only on T.
REQ-038 p0 read granted on T, rst_n low during T+1 -> p0_rvalid stays 0, p0_rdata=0, prio=0 after release.
REQ-039 p1 requests alone while prio=0 -> p1_gnt same cycle; prio=0 next cycle so p0 wins the next tie.
REQ-040 Idle (no requests) for 10 cycles -> ram_cs=0 throughout, prio unchanged, no rvalid pulses.

Source files
------------

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter
//  Description : Two-port round-robin arbiter in front of a single-port
//                synchronous RAM. Each cycle at most one requester is
//                granted combinationally. A granted read returns its data
//                on the following cycle, with a one-cycle rvalid pulse on
//                the owning port.
//  Ports       : clk, rst_n        - clock, async active-low reset
//                pN_req/we/addr/wdata (N=0,1) - requester access inputs
//                pN_gnt            - access accepted this cycle
//                pN_rvalid/rdata   - read return pulse and held read data
//                ram_cs/rw/addr/di - RAM command outputs
//                ram_dout          - RAM read data (one clock after issue)
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int A = 10,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    // requester 0
    input  logic         p0_req,
    input  logic         p0_we,
    input  logic [A-1:0] p0_addr,
    input  logic [D-1:0] p0_wdata,
    output logic         p0_gnt,
    output logic         p0_rvalid,
    output logic [D-1:0] p0_rdata,
    // requester 1
    input  logic         p1_req,
    input  logic         p1_we,
    input  logic [A-1:0] p1_addr,
    input  logic [D-1:0] p1_wdata,
    output logic         p1_gnt,
    output logic         p1_rvalid,
    output logic [D-1:0] p1_rdata,
    // RAM side
    output logic         ram_cs,
    output logic         ram_rw,
    output logic [A-1:0] ram_addr,
    output logic [D-1:0] ram_di,
    input  logic [D-1:0] ram_dout
);

    logic         r_prio;       // port that wins a tie
    logic         r_pend_vld;   // a read was issued on the previous cycle
    logic         r_pend_tag;   // port that owns that read
    logic [D-1:0] r_rdata0;
    logic [D-1:0] r_rdata1;

    logic         w_gnt0;
    logic         w_gnt1;
    logic         w_rd_issue;
    logic         w_rvalid0;
    logic         w_rvalid1;

    // Grants are qualified by rst_n so nothing reaches the RAM while the
    // block is held in reset, whatever the requesters are doing.
    assign w_gnt0 = rst_n & p0_req & (~p1_req | ~r_prio);
    assign w_gnt1 = rst_n & p1_req & (~p0_req |  r_prio);

    assign w_rd_issue = (w_gnt0 & ~p0_we) | (w_gnt1 & ~p1_we);

    assign w_rvalid0 = r_pend_vld & ~r_pend_tag;
    assign w_rvalid1 = r_pend_vld &  r_pend_tag;

    // RAM command mux; all-zero when idle so the bus is quiet.
    always_comb begin
        ram_cs   = 1'b0;
        ram_rw   = 1'b0;
        ram_addr = '0;
        ram_di   = '0;
        if (w_gnt0) begin
            ram_cs   = 1'b1;
            ram_rw   = p0_we;
            ram_addr = p0_addr;
            ram_di   = p0_wdata;
        end else if (w_gnt1) begin
            ram_cs   = 1'b1;
            ram_rw   = p1_we;
            ram_addr = p1_addr;
            ram_di   = p1_wdata;
        end
    end

    // Priority pointer: flips away from whichever port was just served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (w_gnt0) begin
            r_prio <= 1'b1;
        end else if (w_gnt1) begin
            r_prio <= 1'b0;
        end
    end

    // Pending-read tracker. Async reset drops any in-flight return, so no
    // rvalid pulse can follow a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_vld <= 1'b0;
            r_pend_tag <= 1'b0;
        end else begin
            r_pend_vld <= w_rd_issue;
            r_pend_tag <= w_gnt1;
        end
    end

    // Read data holding registers, captured at the end of the return cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (w_rvalid0) r_rdata0 <= ram_dout;
            if (w_rvalid1) r_rdata1 <= ram_dout;
        end
    end

    assign p0_gnt    = w_gnt0;
    assign p1_gnt    = w_gnt1;
    assign p0_rvalid = w_rvalid0;
    assign p1_rvalid = w_rvalid1;
    // Return data is passed straight through during the pulse so the
    // requester sees it with single-cycle latency.
    assign p0_rdata  = w_rvalid0 ? ram_dout : r_rdata0;
    assign p1_rdata  = w_rvalid1 ? ram_dout : r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_arbiter
//  Description : Directed self-checking bench for ram_arbiter with a
//                behavioural synchronous RAM attached to the RAM port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    localparam int A = 10;
    localparam int D = 8;

    logic         clk;
    logic         rst_n;
    logic         p0_req, p0_we, p1_req, p1_we;
    logic [A-1:0] p0_addr, p1_addr;
    logic [D-1:0] p0_wdata, p1_wdata;
    logic         p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [D-1:0] p0_rdata, p1_rdata;
    logic         ram_cs, ram_rw;
    logic [A-1:0] ram_addr;
    logic [D-1:0] ram_di;
    logic [D-1:0] ram_dout;

    int checks   = 0;
    int failures = 0;

    logic [D-1:0] mem [0:(1<<A)-1];

    ram_arbiter #(.A(A), .D(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .ram_cs    (ram_cs),
        .ram_rw    (ram_rw),
        .ram_addr  (ram_addr),
        .ram_di    (ram_di),
        .ram_dout  (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural synchronous RAM.
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_rw) mem[ram_addr] <= ram_di;
            else        ram_dout      <= mem[ram_addr];
        end
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; checks happen 3ns later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < (1<<A); i++) mem[i] = D'(i ^ 8'h5A);
        mem[10'h010] = 8'hA5;
        mem[10'h020] = 8'h11;
        mem[10'h021] = 8'h22;
        ram_dout = '0;
        idle_inputs();
        rst_n = 1'b0;

        // ---- Reset with both ports requesting: nothing granted ----
        p0_req = 1'b1; p1_req = 1'b1;
        next_cycle();
        settle();
        chk("rst_p0_gnt",    32'(p0_gnt),    32'd0);
        chk("rst_p1_gnt",    32'(p1_gnt),    32'd0);
        chk("rst_ram_cs",    32'(ram_cs),    32'd0);
        chk("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
        chk("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
        chk("rst_p0_rdata",  32'(p0_rdata),  32'd0);
        chk("rst_p1_rdata",  32'(p1_rdata),  32'd0);
        next_cycle();
        idle_inputs();
        rst_n = 1'b1;

        // ---- p0 single read of 0x010 ----
        p0_req = 1'b1; p0_addr = 10'h010;
        settle();
        chk("rd_p0_gnt",   32'(p0_gnt),   32'd1);
        chk("rd_p1_gnt",   32'(p1_gnt),   32'd0);
        chk("rd_ram_cs",   32'(ram_cs),   32'd1);
        chk("rd_ram_rw",   32'(ram_rw),   32'd0);
        chk("rd_ram_addr", 32'(ram_addr), 32'h010);
        next_cycle();
        idle_inputs();
        settle();
        chk("rd_p0_rvalid",  32'(p0_rvalid), 32'd1);
        chk("rd_p0_rdata",   32'(p0_rdata),  32'hA5);
        chk("rd_p1_rvalid",  32'(p1_rvalid), 32'd0);
        chk("rd_p1_rdata",   32'(p1_rdata),  32'd0);
        chk("rd_idle_cs",    32'(ram_cs),    32'd0);
        chk("rd_idle_addr",  32'(ram_addr),  32'd0);
        next_cycle();
        settle();
        chk("rd_p0_rvalid_end", 32'(p0_rvalid), 32'd0);
        chk("rd_p0_rdata_held", 32'(p0_rdata),  32'hA5);

        // ---- Both read continuously from reset: p0,p1,p0,p1 ----
        do_reset();
        p0_req = 1'b1; p0_addr = 10'h020;
        p1_req = 1'b1; p1_addr = 10'h021;
        settle();
        chk("alt1_p0_gnt", 32'(p0_gnt), 32'd1);
        chk("alt1_p1_gnt", 32'(p1_gnt), 32'd0);
        chk("alt1_p0_rv",  32'(p0_rvalid), 32'd0);
        next_cycle();
        settle();
        chk("alt2_p1_gnt", 32'(p1_gnt), 32'd1);
        chk("alt2_p0_gnt", 32'(p0_gnt), 32'd0);
        chk("alt2_addr",   32'(ram_addr), 32'h021);
        chk("alt2_p0_rv",  32'(p0_rvalid), 32'd1);
        chk("alt2_p0_rd",  32'(p0_rdata),  32'h11);
        chk("alt2_p1_rv",  32'(p1_rvalid), 32'd0);
        next_cycle();
        settle();
        chk("alt3_p0_gnt", 32'(p0_gnt), 32'd1);
        chk("alt3_p1_rv",  32'(p1_rvalid), 32'd1);
        chk("alt3_p1_rd",  32'(p1_rdata),  32'h22);
        chk("alt3_p0_rv",  32'(p0_rvalid), 32'd0);
        next_cycle();
        settle();
        chk("alt4_p1_gnt", 32'(p1_gnt), 32'd1);
        chk("alt4_p0_rv",  32'(p0_rvalid), 32'd1);
        next_cycle();
        idle_inputs();
        settle();
        chk("alt5_p1_rv",  32'(p1_rvalid), 32'd1);
        chk("alt5_p0_rv",  32'(p0_rvalid), 32'd0);
        chk("alt5_cs",     32'(ram_cs),    32'd0);

        // ---- p1 writes 0x3C to 0x3FF, p0 reads it back next cycle ----
        next_cycle();
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 10'h3FF; p1_wdata = 8'h3C;
        settle();
        chk("wr_p1_gnt",  32'(p1_gnt),   32'd1);
        chk("wr_ram_rw",  32'(ram_rw),   32'd1);
        chk("wr_ram_di",  32'(ram_di),   32'h3C);
        chk("wr_addr",    32'(ram_addr), 32'h3FF);
        next_cycle();
        idle_inputs();
        p0_req = 1'b1; p0_addr = 10'h3FF;
        settle();
        chk("wr_rd_p0_gnt", 32'(p0_gnt),    32'd1);
        chk("wr_rd_rw",     32'(ram_rw),    32'd0);
        chk("wr_no_p1_rv",  32'(p1_rvalid), 32'd0);
        chk("wr_no_p0_rv",  32'(p0_rvalid), 32'd0);
        next_cycle();
        idle_inputs();
        settle();
        chk("wr_rd_p0_rv",  32'(p0_rvalid), 32'd1);
        chk("wr_rd_p0_rd",  32'(p0_rdata),  32'h3C);
        chk("wr_rd_rw_low", 32'(ram_rw),    32'd0);

        // ---- p1 alone while prio=0, then tie goes to p0 ----
        do_reset();
        p1_req = 1'b1; p1_addr = 10'h021;
        settle();
        chk("solo_p1_gnt", 32'(p1_gnt), 32'd1);
        chk("solo_p0_gnt", 32'(p0_gnt), 32'd0);
        next_cycle();
        p0_req = 1'b1; p0_addr = 10'h020;
        settle();
        chk("tie_p0_gnt", 32'(p0_gnt), 32'd1);
        chk("tie_p1_gnt", 32'(p1_gnt), 32'd0);
        chk("tie_p1_rv",  32'(p1_rvalid), 32'd1);
        chk("tie_p1_rd",  32'(p1_rdata),  32'h22);
        next_cycle();
        idle_inputs();
        next_cycle();

        // ---- Reset during read return discards it ----
        do_reset();
        p0_req = 1'b1; p0_addr = 10'h010;
        settle();
        chk("rr_p0_gnt", 32'(p0_gnt), 32'd1);
        next_cycle();
        idle_inputs();
        rst_n = 1'b0;
        settle();
        chk("rr_p0_rv_inrst", 32'(p0_rvalid), 32'd0);
        chk("rr_p0_rd_inrst", 32'(p0_rdata),  32'd0);
        next_cycle();
        rst_n = 1'b1;
        settle();
        chk("rr_p0_rv_after", 32'(p0_rvalid), 32'd0);
        chk("rr_p0_rd_after", 32'(p0_rdata),  32'd0);
        next_cycle();
        p0_req = 1'b1; p0_addr = 10'h020;
        p1_req = 1'b1; p1_addr = 10'h021;
        settle();
        chk("rr_tie_p0", 32'(p0_gnt), 32'd1);
        chk("rr_tie_p1", 32'(p1_gnt), 32'd0);

        // prio is now heading to 1; idle for 10 cycles must not move it.
        next_cycle();
        idle_inputs();
        settle();
        chk("idle0_p0_rv", 32'(p0_rvalid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            settle();
            chk("idle_cs",    32'(ram_cs),    32'd0);
            chk("idle_p0_rv", 32'(p0_rvalid), 32'd0);
            chk("idle_p1_rv", 32'(p1_rvalid), 32'd0);
        end
        next_cycle();
        p0_req = 1'b1; p0_addr = 10'h020;
        p1_req = 1'b1; p1_addr = 10'h021;
        settle();
        chk("idle_tie_p1", 32'(p1_gnt), 32'd1);
        chk("idle_tie_p0", 32'(p0_gnt), 32'd0);
        next_cycle();
        idle_inputs();
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
